// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types and helpers for the word serializer
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH_DEF = 32;

    function automatic int ser_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - saturating bit counter with terminal-count strobe
module ser_bit_counter
    import serializer_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEF
) (
    input  logic cl,
    input  logic cr_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = ser_cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Stops at WIDTH so a stray enable can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge cl or negedge cr_n) begin
        if (!cr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Strobes on the increment that takes the count to WIDTH.
    assign tc_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/reg32_serializer.sv
// rtl/reg32_serializer.sv - loadable word register drained over a valid/ready serial port
module reg32_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic             cl,
    input  logic             cr_n,
    input  logic [WIDTH-1:0] Di,
    input  logic             Load,
    output logic [WIDTH-1:0] Dot,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             done
);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dot_q, dot_d;
    logic             done_q, done_d;
    logic             cnt_clr;
    logic             handshake;
    logic             last_bit;

    assign handshake = (state_q == SHIFT) && ser_ready;

    ser_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .cl    (cl),
        .cr_n  (cr_n),
        .clr_i (cnt_clr),
        .en_i  (handshake),
        .tc_o  (last_bit)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dot_d   = dot_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    shreg_d = Di;
                    dot_d   = Di;
                    cnt_clr = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Load is deliberately ignored here; the word in flight finishes untouched.
                if (handshake) begin
                    shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                    if (last_bit) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cl or negedge cr_n) begin
        if (!cr_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            dot_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dot_q   <= dot_d;
            done_q  <= done_d;
        end
    end

    assign Dot       = dot_q;
    assign busy      = (state_q == SHIFT);
    assign ser_valid = (state_q == SHIFT);
    assign done      = done_q;
    // Cleared shift register keeps ser_out low whenever ser_valid is low.
    assign ser_out   = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: tb/tb_reg32_serializer.sv
// tb/tb_reg32_serializer.sv - scoreboard bench for reg32_serializer
module tb_reg32_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] di32 = '0;
    logic [31:0] dot32;
    logic        load32 = 1'b0, sr32 = 1'b0;
    logic        busy32, so32, sv32, done32;

    logic [7:0]  di8 = '0;
    logic [7:0]  dot8;
    logic        load8 = 1'b0, sr8 = 1'b0;
    logic        busy8, so8, sv8, done8;

    reg32_serializer #(.WIDTH(32), .MSB_FIRST(1)) dut32 (
        .cl(clk), .cr_n(rst_n), .Di(di32), .Load(load32), .Dot(dot32), .busy(busy32),
        .ser_out(so32), .ser_valid(sv32), .ser_ready(sr32), .done(done32)
    );

    reg32_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut8 (
        .cl(clk), .cr_n(rst_n), .Di(di8), .Load(load8), .Dot(dot8), .busy(busy8),
        .ser_out(so8), .ser_valid(sv8), .ser_ready(sr8), .done(done8)
    );

    bit          exp32[$];
    bit          exp8[$];
    bit          b32, b8;
    logic [31:0] rx32 = '0;
    logic [7:0]  rx8 = '0;
    logic        held_v32 = 1'b0;
    logic        held_b32 = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    // Handshakes are decided by ser_valid/ser_ready as seen at the negedge before the edge.
    always @(negedge clk) begin
        if (sv32 && held_v32) begin
            n_checks++;
            if (so32 !== held_b32) begin
                n_fail++;
                $display("FAIL stall_hold32: ser_out=%b expected %b", so32, held_b32);
            end
        end
        held_v32 = sv32 && !sr32;
        held_b32 = so32;
        if (sv32 && sr32) begin
            n_checks++;
            if (exp32.size() == 0) begin
                n_fail++;
                $display("FAIL sb32_extra: bit %b sent with nothing expected", so32);
            end else begin
                b32 = exp32.pop_front();
                if (so32 !== b32) begin
                    n_fail++;
                    $display("FAIL sb32_bit: ser_out=%b expected %b", so32, b32);
                end
            end
            rx32 = {rx32[30:0], so32};
        end
        if (sv8 && sr8) begin
            n_checks++;
            if (exp8.size() == 0) begin
                n_fail++;
                $display("FAIL sb8_extra: bit %b sent with nothing expected", so8);
            end else begin
                b8 = exp8.pop_front();
                if (so8 !== b8) begin
                    n_fail++;
                    $display("FAIL sb8_bit: ser_out=%b expected %b", so8, b8);
                end
            end
            rx8 = {so8, rx8[7:1]};
        end
    end

    task automatic push32(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) exp32.push_back(w[i]);
    endtask

    task automatic push8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) exp8.push_back(w[i]);
    endtask

    // Returns posedges elapsed until done is seen high, or -1 on timeout.
    task automatic wait_done32(output int edges);
        edges = 0;
        while (edges < 600) begin
            @(negedge clk);
            if (done32 === 1'b1) return;
            @(posedge clk);
            edges++;
        end
        edges = -1;
    endtask

    task automatic load_word32(input logic [31:0] w);
        di32 = w;
        load32 = 1'b1;
        push32(w);
        @(posedge clk);
        #1 load32 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy32, sv32, so32, done32, busy8, sv8, so8, done8} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {busy32, sv32, so32, done32, busy8, sv8, so8, done8});
        end
        n_checks++;
        if (dot32 !== 32'h0 || dot8 !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_dot: got %h/%h expected 0/0", dot32, dot8);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_msb_first;
        int e;
        @(posedge clk); #1;
        sr32 = 1'b1;
        load_word32(32'h8000_0001);
        n_checks++;
        if (dot32 !== 32'h8000_0001) begin
            n_fail++;
            $display("FAIL msb_dot_start: got %h expected 80000001", dot32);
        end
        wait_done32(e);
        n_checks++;
        if (e !== 32) begin
            n_fail++;
            $display("FAIL msb_done_latency: got %0d expected 32", e);
        end
        n_checks++;
        if (rx32 !== 32'h8000_0001 || dot32 !== 32'h8000_0001) begin
            n_fail++;
            $display("FAIL msb_word: rx=%h dot=%h expected 80000001", rx32, dot32);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done32 !== 1'b0 || busy32 !== 1'b0) begin
            n_fail++;
            $display("FAIL msb_done_pulse: done=%b busy=%b expected 0 0", done32, busy32);
        end
    endtask

    task automatic test_reset_midword;
        int e;
        @(posedge clk); #1;
        sr32 = 1'b1;
        load_word32(32'hA5A5_A5A5);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy32, sv32, so32, done32} !== 4'b0000 || dot32 !== 32'h0) begin
            n_fail++;
            $display("FAIL midword_reset: outs=%b dot=%h expected 0000 0",
                     {busy32, sv32, so32, done32}, dot32);
        end
        n_checks++;
        if (exp32.size() !== 22) begin
            n_fail++;
            $display("FAIL midword_sent: remaining=%0d expected 22", exp32.size());
        end
        exp32.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        load_word32(32'h0000_0001);
        wait_done32(e);
        n_checks++;
        if (e !== 32 || rx32 !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL midword_reload: edges=%0d rx=%h expected 32 00000001", e, rx32);
        end
    endtask

    task automatic test_backpressure;
        int  hs;
        logic pend;
        logic seen;
        hs = 0;
        pend = 1'b0;
        seen = 1'b0;
        @(posedge clk); #1;
        load_word32(32'hF0F0_F0F0);
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            sr32 = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_checks++;
            if (done32 !== pend) begin
                n_fail++;
                $display("FAIL bp_done_timing: done=%b expected %b after %0d handshakes",
                         done32, pend, hs);
            end
            seen = (done32 === 1'b1);
            pend = sv32 && sr32 && (hs == 31);
            if (sv32 && sr32) hs++;
            @(posedge clk); #1;
        end
        sr32 = 1'b1;
        n_checks++;
        if (!seen || hs !== 32 || rx32 !== 32'hF0F0_F0F0) begin
            n_fail++;
            $display("FAIL bp_word: seen=%b hs=%0d rx=%h expected 1 32 f0f0f0f0", seen, hs, rx32);
        end
    endtask

    task automatic test_load_while_busy;
        int e;
        @(posedge clk); #1;
        sr32 = 1'b1;
        load_word32(32'h1234_5678);
        repeat (5) @(posedge clk);
        #1 di32 = 32'hFFFF_FFFF;
        load32 = 1'b1;
        @(posedge clk);
        #1 load32 = 1'b0;
        n_checks++;
        if (dot32 !== 32'h1234_5678 || busy32 !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_load_ignored: dot=%h busy=%b expected 12345678 1", dot32, busy32);
        end
        wait_done32(e);
        n_checks++;
        if (e !== 26 || rx32 !== 32'h1234_5678 || dot32 !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL busy_word: edges=%0d rx=%h dot=%h expected 26 12345678 12345678",
                     e, rx32, dot32);
        end
    endtask

    task automatic test_back_to_back;
        int e;
        @(posedge clk); #1;
        sr32 = 1'b1;
        load_word32(32'h0F1E_2D3C);
        wait_done32(e);
        n_checks++;
        if (e !== 32 || rx32 !== 32'h0F1E_2D3C) begin
            n_fail++;
            $display("FAIL b2b_first: edges=%0d rx=%h expected 32 0f1e2d3c", e, rx32);
        end
        load_word32(32'hDEAD_BEEF);
        n_checks++;
        if (busy32 !== 1'b1 || sv32 !== 1'b1 || dot32 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL b2b_capture: busy=%b valid=%b dot=%h expected 1 1 deadbeef",
                     busy32, sv32, dot32);
        end
        wait_done32(e);
        n_checks++;
        if (e !== 32 || rx32 !== 32'hDEAD_BEEF || exp32.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_second: edges=%0d rx=%h left=%0d expected 32 deadbeef 0",
                     e, rx32, exp32.size());
        end
    endtask

    task automatic test_lsb_first8;
        int e;
        @(posedge clk); #1;
        sr8 = 1'b1;
        di8 = 8'h01;
        load8 = 1'b1;
        push8(8'h01);
        @(posedge clk);
        #1 load8 = 1'b0;
        e = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                e = i;
                break;
            end
            @(posedge clk);
        end
        n_checks++;
        if (e !== 8) begin
            n_fail++;
            $display("FAIL lsb8_done_latency: got %0d expected 8", e);
        end
        n_checks++;
        if (rx8 !== 8'h01 || dot8 !== 8'h01 || exp8.size() !== 0) begin
            n_fail++;
            $display("FAIL lsb8_word: rx=%h dot=%h left=%0d expected 01 01 0", rx8, dot8, exp8.size());
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_reset_midword();
        test_backpressure();
        test_load_while_busy();
        test_back_to_back();
        test_lsb_first8();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
